// File: rtl/llki_key_sequencer.sv
// Drives one TSS core's LLKI discrete key port: LOAD/CLEAR commands plus a
// 64-bit key word stream in, one status response per command out.
`timescale 1ns/1ps

module llki_key_sequencer #(
    parameter int KEY_WORDS      = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        sys_clk_50,
    input  logic        sync_rst_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_opcode,
    input  logic [7:0]  cmd_len,
    input  logic [63:0] kw_data,
    input  logic        kw_valid,
    output logic        kw_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic        key_loaded,
    output logic [63:0] llkid_key_data,
    output logic        llkid_key_valid,
    input  logic        llkid_key_ready,
    input  logic        llkid_key_complete,
    output logic        llkid_clear_key,
    input  logic        llkid_clear_key_ack
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] KW_LEN  = 8'(KEY_WORDS);
    localparam logic [7:0] KW_LAST = 8'(KEY_WORDS - 1);

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR_LEN = 2'd1;
    localparam logic [1:0] ST_ERR_OP  = 2'd2;
    localparam logic [1:0] ST_ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_WORD,
        S_SEND_WORD,
        S_WAIT_CMPL,
        S_CLR_REQ,
        S_RESP
    } state_t;

    state_t        state_q;
    logic [7:0]    cnt_q;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic          tmo_hit;
    logic          cmd_ready_q;
    logic          kw_ready_q;
    logic          rsp_valid_q;
    logic [1:0]    rsp_status_q;
    logic          key_loaded_q;
    logic [63:0]   data_q;
    logic          key_valid_q;
    logic          clear_q;

    assign tmo_d   = tmo_q + 1'b1;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(posedge sys_clk_50) begin
        if (sync_rst_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            cmd_ready_q  <= 1'b0;
            kw_ready_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            key_loaded_q <= 1'b0;
            data_q       <= '0;
            key_valid_q  <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_opcode == OP_LOAD) begin
                            key_loaded_q <= 1'b0;
                            if (cmd_len == KW_LEN) begin
                                cnt_q      <= '0;
                                kw_ready_q <= 1'b1;
                                state_q    <= S_GET_WORD;
                            end else begin
                                rsp_valid_q  <= 1'b1;
                                rsp_status_q <= ST_ERR_LEN;
                                state_q      <= S_RESP;
                            end
                        end else if (cmd_opcode == OP_CLEAR) begin
                            clear_q <= 1'b1;
                            tmo_q   <= '0;
                            state_q <= S_CLR_REQ;
                        end else begin
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= ST_ERR_OP;
                            state_q      <= S_RESP;
                        end
                    end
                end
                S_GET_WORD: begin
                    if (kw_valid) begin
                        data_q      <= kw_data;
                        kw_ready_q  <= 1'b0;
                        key_valid_q <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= S_SEND_WORD;
                    end
                end
                S_SEND_WORD: begin
                    if (llkid_key_ready) begin
                        key_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + 8'd1;
                        if (cnt_q == KW_LAST) begin
                            tmo_q   <= '0;
                            state_q <= S_WAIT_CMPL;
                        end else begin
                            kw_ready_q <= 1'b1;
                            state_q    <= S_GET_WORD;
                        end
                    end else if (tmo_hit) begin
                        key_valid_q  <= 1'b0;
                        key_loaded_q <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_ERR_TMO;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_WAIT_CMPL: begin
                    if (llkid_key_complete) begin
                        key_loaded_q <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_OK;
                        state_q      <= S_RESP;
                    end else if (tmo_hit) begin
                        key_loaded_q <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_ERR_TMO;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_CLR_REQ: begin
                    // An ack arriving in the expiry cycle still counts as success.
                    if (llkid_clear_key_ack || tmo_hit) begin
                        clear_q      <= 1'b0;
                        key_loaded_q <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= llkid_clear_key_ack ? ST_OK : ST_ERR_TMO;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign kw_ready        = kw_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_status      = rsp_status_q;
    assign key_loaded      = key_loaded_q;
    assign llkid_key_data  = data_q;
    assign llkid_key_valid = key_valid_q;
    assign llkid_clear_key = clear_q;

endmodule

// File: tb/tb_llki_key_sequencer.sv
// Bench for llki_key_sequencer: directed and random commands against a
// host/target model that decides each command's outcome from its rules.
`timescale 1ns/1ps

module tb_llki_key_sequencer;

    localparam int KW  = 5;
    localparam int TMO = 1024;

    logic        sys_clk_50 = 1'b0;
    logic        sync_rst_in = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode = 2'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic [63:0] kw_data = 64'd0;
    logic        kw_valid = 1'b0;
    logic        kw_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic        key_loaded;
    logic [63:0] llkid_key_data;
    logic        llkid_key_valid;
    logic        llkid_key_ready = 1'b0;
    logic        llkid_key_complete = 1'b0;
    logic        llkid_clear_key;
    logic        llkid_clear_key_ack = 1'b0;

    always #5 sys_clk_50 = ~sys_clk_50;

    llki_key_sequencer #(.KEY_WORDS(KW), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk_50         (sys_clk_50),
        .sync_rst_in        (sync_rst_in),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_opcode         (cmd_opcode),
        .cmd_len            (cmd_len),
        .kw_data            (kw_data),
        .kw_valid           (kw_valid),
        .kw_ready           (kw_ready),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_status         (rsp_status),
        .key_loaded         (key_loaded),
        .llkid_key_data     (llkid_key_data),
        .llkid_key_valid    (llkid_key_valid),
        .llkid_key_ready    (llkid_key_ready),
        .llkid_key_complete (llkid_key_complete),
        .llkid_clear_key    (llkid_clear_key),
        .llkid_clear_key_ack(llkid_clear_key_ack)
    );

    int n_asserts = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shared model state; each variable has a single writing process.
    int          cyc = 0;
    logic [63:0] host_q[$];
    int          host_start = 0;
    int          kw_idx = 0;
    bit          host_stall = 0;
    logic [63:0] rx_q[$];
    int          last_xfer_edge = 0;
    int          stall_cyc = 0;
    int          cmpl_delay = 0;
    int          ack_delay = 0;
    int          cmd_seq = 0;
    int          seen_seq = 0;
    int          rx_base_t = 0;
    int          wait_cnt = 0;
    int          cdel_cnt = 0;
    int          ack_cnt = 0;
    int          clr_hi = 0;
    int          kw_ready_seen = 0;
    bit          mon_en = 0;
    bit          hold_pend = 0;
    logic [63:0] hold_data = 64'd0;

    function automatic int cur_idx();
        return (kw_idx > host_start) ? kw_idx : host_start;
    endfunction

    always @(posedge sys_clk_50) begin
        cyc++;
        if (!sync_rst_in && llkid_key_valid && llkid_key_ready) begin
            rx_q.push_back(llkid_key_data);
            last_xfer_edge = cyc;
        end
        if (!sync_rst_in && kw_valid && kw_ready)
            kw_idx = cur_idx() + 1;
        hold_pend = !sync_rst_in && llkid_key_valid && !llkid_key_ready;
        hold_data = llkid_key_data;
    end

    always @(negedge sys_clk_50) begin
        if (seen_seq != cmd_seq) begin
            seen_seq = cmd_seq;
            rx_base_t = rx_q.size();
            cdel_cnt = 0;
            clr_hi = 0;
            llkid_key_complete = 1'b0;
        end
        if (mon_en && hold_pend) begin
            check("hold_valid", 64'(llkid_key_valid), 64'(1));
            check("hold_data", llkid_key_data, hold_data);
        end
        if (kw_ready) kw_ready_seen++;
        if (llkid_key_valid) begin
            llkid_key_ready = (wait_cnt >= stall_cyc);
            wait_cnt++;
        end else begin
            llkid_key_ready = 1'b0;
            wait_cnt = 0;
        end
        if (rx_q.size() - rx_base_t >= KW && cmpl_delay >= 0) begin
            if (cdel_cnt >= cmpl_delay) llkid_key_complete = 1'b1;
            cdel_cnt++;
        end
        if (llkid_clear_key) begin
            clr_hi++;
            ack_cnt++;
            llkid_clear_key_ack = (ack_delay >= 0) && (ack_cnt >= ack_delay);
        end else begin
            llkid_clear_key_ack = 1'b0;
            ack_cnt = 0;
        end
        kw_valid = (cur_idx() < host_q.size()) &&
                   (!host_stall || $urandom_range(0, 3) != 0);
        kw_data = kw_valid ? host_q[cur_idx()] : {$urandom, $urandom};
    end

    function automatic logic [1:0] model_status(input logic [1:0] op,
        input logic [7:0] len, input int cdel, input int adel);
        if (op == 2'd1) begin
            if (int'(len) != KW) return 2'd1;
            return (cdel >= 0) ? 2'd0 : 2'd3;
        end
        if (op == 2'd2) return (adel >= 0) ? 2'd0 : 2'd3;
        return 2'd2;
    endfunction

    bit  kl_model = 0;
    int  g_rxb, g_kwr, g_hb, g_acc_edge, g_rsp_edge;

    task automatic issue_cmd(input logic [1:0] op, input logic [7:0] len,
        input int stall, input int cdel, input int adel,
        input bit hstall, input bit seqw);
        bit got;
        int n;
        @(negedge sys_clk_50);
        #1;
        stall_cyc = stall;
        cmpl_delay = cdel;
        ack_delay = adel;
        host_stall = hstall;
        g_rxb = rx_q.size();
        g_kwr = kw_ready_seen;
        host_start = host_q.size();
        g_hb = host_start;
        n = (op == 2'd1) ? int'(len) : 2;
        for (int i = 0; i < n; i++)
            host_q.push_back(seqw ? 64'(i + 1) : {$urandom, $urandom});
        cmd_seq++;
        @(negedge sys_clk_50);
        cmd_valid = 1'b1;
        cmd_opcode = op;
        cmd_len = len;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                got = 1;
                break;
            end
            @(negedge sys_clk_50);
        end
        check("cmd_accept", 64'(got), 64'(1));
        g_acc_edge = cyc + 1;
        @(negedge sys_clk_50);
        cmd_valid = 1'b0;
        cmd_opcode = 2'($urandom);
        cmd_len = 8'($urandom);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] len,
        input int stall, input int cdel, input int adel,
        input bit hstall, input int rdly, input bit seqw);
        bit got;
        logic [1:0] st;
        logic [1:0] exp;
        bit good_load;
        int nrx;
        issue_cmd(op, len, stall, cdel, adel, hstall, seqw);
        exp = model_status(op, len, cdel, adel);
        good_load = (op == 2'd1) && (int'(len) == KW);
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid) begin
                got = 1;
                break;
            end
            @(negedge sys_clk_50);
        end
        g_rsp_edge = cyc;
        check("rsp_seen", 64'(got), 64'(1));
        st = rsp_status;
        for (int i = 0; i < rdly; i++) begin
            @(negedge sys_clk_50);
            check("rsp_hold", 64'({rsp_valid, rsp_status}), 64'({1'b1, st}));
        end
        rsp_ready = 1'b1;
        @(negedge sys_clk_50);
        rsp_ready = 1'b0;
        check("rsp_status", 64'(st), 64'(exp));
        check("rsp_drop", 64'(rsp_valid), 64'(0));
        check("cmd_ready_back", 64'(cmd_ready), 64'(1));
        if (op == 2'd1) kl_model = (exp == 2'd0);
        else if (op == 2'd2) kl_model = 0;
        check("key_loaded", 64'(key_loaded), 64'(kl_model));
        check("kw_consumed", 64'(cur_idx() - g_hb), 64'(good_load ? KW : 0));
        if (exp == 2'd1 || exp == 2'd2)
            check("err_latency", 64'(g_rsp_edge - g_acc_edge), 64'(0));
        if (!good_load) begin
            check("kw_ready_quiet", 64'(kw_ready_seen - g_kwr), 64'(0));
        end else begin
            nrx = rx_q.size() - g_rxb;
            check("rx_count", 64'(nrx), 64'(KW));
            for (int i = 0; i < KW && i < nrx; i++)
                check("rx_word", rx_q[g_rxb + i], host_q[g_hb + i]);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_rsp;
        int r;
        logic [1:0] op;
        logic [7:0] len;

        repeat (3) @(negedge sys_clk_50);
        check("reset_outs", 64'({cmd_ready, kw_ready, rsp_valid, rsp_status,
              key_loaded, llkid_key_valid, llkid_clear_key}), 64'(0));
        check("reset_data", llkid_key_data, 64'd0);
        sync_rst_in = 1'b0;
        @(negedge sys_clk_50);
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

        mon_en = 1;
        run_cmd(2'd1, 8'd5, 0, 0, 0, 0, 0, 1);
        check("ideal_latency", 64'(g_rsp_edge - g_acc_edge + 1), 64'(12));

        run_cmd(2'd1, 8'd5, 10, 0, 0, 0, 2, 0);
        run_cmd(2'd1, 8'd4, 0, 0, 0, 0, 1, 0);
        run_cmd(2'd3, 8'd5, 0, 0, 0, 0, 0, 0);
        run_cmd(2'd0, 8'd5, 0, 0, 0, 0, 0, 0);

        run_cmd(2'd1, 8'd5, 0, 0, 0, 0, 0, 0);
        run_cmd(2'd2, 8'd0, 0, 0, 3, 0, 0, 0);
        check("clear_high_cycles", 64'(clr_hi >= 3), 64'(1));

        run_cmd(2'd1, 8'd5, 0, -1, 0, 0, 0, 0);
        check("timeout_cycles", 64'(g_rsp_edge - last_xfer_edge), 64'(TMO));

        mon_en = 0;
        issue_cmd(2'd1, 8'd5, 10, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            if (rx_q.size() - g_rxb == 2 && llkid_key_valid) break;
            @(negedge sys_clk_50);
        end
        check("third_send_reached", 64'(llkid_key_valid), 64'(1));
        sync_rst_in = 1'b1;
        @(negedge sys_clk_50);
        check("midop_reset_outs", 64'({cmd_ready, kw_ready, rsp_valid, rsp_status,
              key_loaded, llkid_key_valid, llkid_clear_key}), 64'(0));
        check("midop_reset_data", llkid_key_data, 64'd0);
        sync_rst_in = 1'b0;
        kl_model = 0;
        @(negedge sys_clk_50);
        check("cmd_ready_after_midop", 64'(cmd_ready), 64'(1));
        any_rsp = 0;
        repeat (20) begin
            @(negedge sys_clk_50);
            if (rsp_valid) any_rsp = 1;
        end
        check("no_rsp_after_reset", 64'(any_rsp), 64'(0));
        check("abandoned_xfers", 64'(rx_q.size() - g_rxb), 64'(2));
        mon_en = 1;
        run_cmd(2'd1, 8'd5, 1, 1, 0, 1, 0, 0);

        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 9);
            op = (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
            len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'd5;
            run_cmd(op, len, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 4), 1, $urandom_range(0, 3), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
